// File: rtl/crc_serial_if.sv
// Word-in / CRC-out bus for crc_serial. The source drives the master side and
// the CRC engine implements the slave side.
interface crc_serial_if #(
    parameter int WIDTH = 8,
    parameter int DW    = 8
);
    logic             clear;
    logic             din_valid;
    logic             din_ready;
    logic [DW-1:0]    din;
    logic             din_last;
    logic [WIDTH-1:0] crc_out;
    logic             crc_valid;
    logic             crc_ok;
    logic             busy;

    modport master (
        output clear, din_valid, din, din_last,
        input  din_ready, crc_out, crc_valid, crc_ok, busy
    );

    modport slave (
        input  clear, din_valid, din, din_last,
        output din_ready, crc_out, crc_valid, crc_ok, busy
    );
endinterface

// File: rtl/crc_serial.sv
// Bit-serial CRC engine: takes one DW-bit word at a time and folds it into the
// CRC register one bit per clock, pulsing crc_valid after the frame's last word.
module crc_serial #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] POLY      = 8'h31,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter int               DW        = 8,
    parameter int               LSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    crc_serial_if.slave  bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] crc;
    logic [WIDTH-1:0] crc_next;
    logic [DW-1:0]    sh;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             in_frame;
    logic             crc_valid;
    logic             busy;
    logic             bit_in;
    logic             fb;

    assign bus.din_ready = (state == IDLE) && !bus.clear;
    assign bus.crc_out   = crc;
    assign bus.crc_ok    = (crc == '0);
    assign bus.crc_valid = crc_valid;
    assign bus.busy      = busy;

    always_comb begin
        bit_in   = (LSB_FIRST != 0) ? sh[0] : sh[DW-1];
        fb       = crc[WIDTH-1] ^ bit_in;
        crc_next = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            // clear behaves like reset except it leaves the datapath shifter alone
            state     <= IDLE;
            crc       <= INIT;
            in_frame  <= 1'b0;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            if (rst) begin
                sh   <= '0;
                last <= 1'b0;
            end
        end else begin
            crc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.din_valid) begin
                        sh       <= bus.din;
                        last     <= bus.din_last;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        in_frame <= 1'b1;
                        state    <= SHIFT;
                        if (!in_frame)
                            crc <= INIT;
                    end
                end
                SHIFT: begin
                    crc <= crc_next;
                    sh  <= (LSB_FIRST != 0) ? (sh >> 1) : (sh << 1);
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        busy <= 1'b0;
                        if (last) begin
                            state     <= DONE;
                            crc_valid <= 1'b1;
                            in_frame  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/crc_serial.md
CRC_SERIAL -- requirements
Module: crc_serial

Interface
REQ-001 Parameter WIDTH, default 8, CRC register width (2..32).
REQ-002 Parameter POLY, default 8'h31, generator polynomial in normal form without the x^WIDTH term; the default is x^8+x^5+x^4+1, as used by Dallas/Maxim 1-Wire.
REQ-003 Parameter INIT, default 0, CRC register start value for each frame.
REQ-004 Parameter DW, default 8, data word width per beat (1..64).
REQ-005 Parameter LSB_FIRST, default 1, bit order within a word: 1 feeds din[0] first; 0 feeds din[DW-1] first.
REQ-006 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port clear, input, 1, synchronous frame abort and restart.
REQ-009 Port din_valid, input, 1, din and din_last are valid.
REQ-010 Port din_ready, output, 1, block can accept a word this cycle.
REQ-011 Port din, input, DW, data word.
REQ-012 Port din_last, input, 1, word is the last word of the frame.
REQ-013 Port crc_out, output, WIDTH, current CRC register value.
REQ-014 Port crc_valid, output, 1, one-cycle pulse marking the final frame CRC.
REQ-015 Port crc_ok, output, 1, high when crc_out == 0 (residue check).
REQ-016 Port busy, output, 1, word is being serialised.

Function
REQ-017 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-018 din_ready SHALL be 1 only when the state is IDLE and clear is 0 (combinational).
REQ-019 A word SHALL be accepted on the rising edge where din_valid && din_ready; din and din_last are captured and the state moves to SHIFT.
REQ-020 On acceptance of the first word of a frame (after reset, clear, or DONE), crc SHALL load INIT before any bit is processed.
REQ-021 Each SHIFT cycle SHALL process exactly one bit b: fb = crc[WIDTH-1]^b; crc <= {crc[WIDTH-2:0],0} ^ (fb ? POLY : 0).
REQ-022 The captured word SHALL be processed over exactly DW consecutive SHIFT cycles, in bit order set by LSB_FIRST.
REQ-023 After the DW-th bit, the state SHALL move to IDLE if din_last was 0, or to DONE if din_last was 1.
REQ-024 DONE SHALL last exactly one cycle with crc_valid=1, then the state SHALL move to IDLE.
REQ-025 Latency SHALL be as follows: if the last word is accepted at edge k, crc_valid is high during the cycle following edge k+DW.
REQ-026 The maximum throughput SHALL be one word per DW+1 cycles, or DW+2 cycles for a last word.
REQ-027 busy SHALL equal (state==SHIFT).
REQ-028 crc_out SHALL hold its value in IDLE and DONE, and retain the final CRC until the next frame's first word is accepted.
REQ-029 crc_ok SHALL be combinational from crc_out, and is meaningful when crc_valid=1.
REQ-030 clear=1 in any state SHALL force IDLE, set crc to INIT, drop any word in progress, suppress crc_valid, and start a new frame.
REQ-031 If clear and din_valid are both high in the same cycle, clear SHALL win and the word SHALL NOT be accepted.
REQ-032 din_valid while din_ready=0 SHALL be ignored; the source must hold the word until it is accepted.

Reset
REQ-033 rst=1 at a rising edge SHALL force state IDLE and crc=INIT; crc_valid=0, busy=0.
REQ-034 rst SHALL take priority over clear and din_valid.
REQ-035 rst asserted mid-SHIFT SHALL discard the partial word.
REQ-036 After reset deasserts, din_ready SHALL be 1 in the first cycle, and the next accepted word SHALL start a new frame.

Verification
REQ-037 Defaults: single word 0x00 with last -> crc_valid pulse 9 cycles after acceptance; crc_out=0x00, crc_ok=1.
REQ-038 Defaults: single word 0x01 with last -> crc_out=0x7A, crc_ok=0.
REQ-039 Defaults: frame 0x01 then 0x5E (last) -> crc_out=0x00, crc_ok=1; din_ready is low for the 8 SHIFT cycles after each acceptance; one crc_valid pulse only.
REQ-040 Defaults: accept 0x01 (last=0), assert clear in the 4th SHIFT cycle, then send 0x01 (last) -> crc_out=0x7A; no crc_valid before the final frame.
REQ-041 Defaults: assert clear and din_valid in the same cycle -> word not accepted, din_ready=0 that cycle, crc_out=INIT.
REQ-042 Random frames at WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, DW=8, LSB_FIRST=0 -> crc_out matches a bitwise CRC-16/CCITT-FALSE model ("123456789" -> 0x29B1); rst asserted mid-frame -> IDLE next cycle, crc_out=0xFFFF.
